// File: rtl/sample_tribus_pkg.sv
// Shared types and constants for the tri-state bus arbiter.
package sample_tribus_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Width of the beat counter output.
    localparam int CNT_W = 8;

    // Ceiling log2, with a minimum of 1 so that 2-entry indices still get a bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_rr_pick.sv
// Rotate-priority encoder: finds the first asserted request at or after rr_ptr,
// wrapping past the top channel back to channel 0.
module sample_rr_pick #(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [IDX_W-1:0]    winner,
    output logic                any
);

    // Scan from the farthest rotated position toward rr_ptr so the nearest hit is written last.
    always_comb begin
        logic [IDX_W-1:0] idx_s;
        winner = '0;
        any    = 1'b0;
        idx_s  = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx_s  = IDX_W'((int'(rr_ptr) + k) % CHANNELS);
            winner = req[idx_s] ? idx_s : winner;
            any    = any | req[idx_s];
        end
    end

endmodule

// File: rtl/sample_tribus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus built from bufif1 gates.
// Each tenure lasts at most HOLD_MAX beats and is followed by a one-cycle
// turnaround plus one idle cycle before the next owner can drive.
// Optional build macro SAMPLE_TRIBUS_PULLUP_EN adds a pullup on every bus bit
// so the released bus reads all-ones instead of floating.
module sample_tribus_arbiter
    import sample_tribus_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int HOLD_MAX = 4,
    localparam int IDX_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] wr_data,
    output logic [CHANNELS-1:0]       grant,
    inout  tri   [WIDTH-1:0]          bus,
    output logic                      bus_valid,
    output logic [IDX_W-1:0]          bus_owner,
    output logic [CNT_W-1:0]          beat_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);
    localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(CHANNELS - 1);

    state_t                state_r,  state_s;
    logic [CHANNELS-1:0]   grant_r,  grant_s;
    logic                  valid_r,  valid_s;
    logic [IDX_W-1:0]      owner_r,  owner_s;
    logic [CNT_W-1:0]      cnt_r,    cnt_s;
    logic [IDX_W-1:0]      rr_ptr_r, rr_ptr_s;
    logic [IDX_W-1:0]      pick_winner_s;
    logic                  pick_any_s;

    sample_rr_pick #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .winner (pick_winner_s),
        .any    (pick_any_s)
    );

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        valid_s  = valid_r;
        owner_s  = owner_r;
        cnt_s    = cnt_r;
        rr_ptr_s = rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s = GRANT;
                    grant_s = CHANNELS'(1) << pick_winner_s;
                    valid_s = 1'b1;
                    owner_s = pick_winner_s;
                    cnt_s   = '0;
                end else begin
                    grant_s = '0;
                    valid_s = 1'b0;
                end
            end
            GRANT: begin
                // Owner release or last allowed beat both close the tenure on this edge.
                if (!req[owner_r] || (cnt_r >= HOLD_LAST)) begin
                    state_s  = TURN;
                    grant_s  = '0;
                    valid_s  = 1'b0;
                    rr_ptr_s = (owner_r == LAST_CH) ? '0 : owner_r + IDX_W'(1);
                end else begin
                    cnt_s = (cnt_r < HOLD_SAT) ? cnt_r + CNT_W'(1) : cnt_r;
                end
            end
            TURN: begin
                state_s = IDLE;
                grant_s = '0;
                valid_s = 1'b0;
            end
            default: begin
                state_s = IDLE;
                grant_s = '0;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops every driver enable immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            valid_r  <= 1'b0;
            owner_r  <= '0;
            cnt_r    <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_s;
            grant_r  <= grant_s;
            valid_r  <= valid_s;
            owner_r  <= owner_s;
            cnt_r    <= cnt_s;
            rr_ptr_r <= rr_ptr_s;
        end
    end

    assign grant     = grant_r;
    assign bus_valid = valid_r;
    assign bus_owner = owner_r;
    assign beat_cnt  = cnt_r;

    // One bufif1 per channel per bit; grant_r is one-hot or zero, so at most one channel drives.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            bufif1 u_drv (bus[b], wr_data[ch*WIDTH + b], grant_r[ch]);
        end
    end

`ifdef SAMPLE_TRIBUS_PULLUP_EN
    // Weak pull so a released bus settles to all-ones.
    for (genvar b = 0; b < WIDTH; b++) begin : g_pull
        pullup u_pull (bus[b]);
    end
`else
    // No pull: a released bus floats.
`endif

endmodule

// File: tb/tb_sample_tribus_arbiter.sv
// Directed bench for sample_tribus_arbiter with a tenure-level reference model.
`timescale 1ns/1ps
module tb_sample_tribus_arbiter;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int HOLD_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wr_data;
    tri   [7:0]  bus;
    logic [3:0]  grant;
    logic        bus_valid;
    logic [1:0]  bus_owner;
    logic [7:0]  beat_cnt;
    logic        bus_idle;

    int n_vec = 0;
    int n_err = 0;

    sample_tribus_arbiter #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr_data   (wr_data),
        .grant     (grant),
        .bus       (bus),
        .bus_valid (bus_valid),
        .bus_owner (bus_owner),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

`ifdef SAMPLE_TRIBUS_PULLUP_EN
    assign bus_idle = (bus === 8'hFF);
`else
    assign bus_idle = (bus === 8'hzz);
`endif

    // ---------------- reference model (tenure level) ----------------
    logic m_active = 1'b0;
    logic m_turn   = 1'b0;
    logic chk_en   = 1'b0;
    int   m_owner  = 0;
    int   m_last   = 0;
    int   m_beats  = 0;
    int   m_ptr    = 0;

    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < CHANNELS; k++) begin
            if (r[(ptr + k) % CHANNELS]) return (ptr + k) % CHANNELS;
        end
        return 0;
    endfunction

    // Advance the model by one clock using the request levels seen at this edge.
    always @(posedge clk) begin
        chk_en <= 1'b1;
        if (rst) begin
            m_active <= 1'b0;
            m_turn   <= 1'b0;
            m_ptr    <= 0;
            m_last   <= 0;
            m_owner  <= 0;
            m_beats  <= 0;
        end else if (m_active) begin
            if (!req[m_owner] || m_beats == HOLD_MAX - 1) begin
                m_active <= 1'b0;
                m_turn   <= 1'b1;
                m_ptr    <= (m_owner + 1) % CHANNELS;
            end else begin
                m_beats <= m_beats + 1;
            end
        end else if (m_turn) begin
            m_turn <= 1'b0;
        end else if (req != 4'b0000) begin
            m_active <= 1'b1;
            m_owner  <= pick(req, m_ptr);
            m_last   <= pick(req, m_ptr);
            m_beats  <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("grant",     {28'd0, grant},     m_active ? (32'd1 << m_owner) : 32'd0);
            check("bus_valid", {31'd0, bus_valid}, {31'd0, m_active});
            check("bus_owner", {30'd0, bus_owner}, m_last);
            check("beat_cnt",  {24'd0, beat_cnt},  m_beats);
            n_vec++;
            if (m_active ? (bus !== wr_data[m_owner*8 +: 8]) : !bus_idle) begin
                n_err++;
                $display("FAIL bus: got %h expected %s at %0t", bus,
                         m_active ? "owner data" : "idle level", $time);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input int budget, output logic [3:0] g, output int n);
        n = 0;
        g = 4'b0000;
        while (g == 4'b0000 && n < budget) begin
            tick(1);
            n++;
            g = grant;
        end
        if (g == 4'b0000) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_grant: no grant within %0d cycles", budget);
        end
    endtask

    task automatic wait_release(input int budget, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (grant != 4'b0000 && n < budget);
        if (grant != 4'b0000) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_release: grant held beyond %0d cycles", budget);
        end
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if (!bus_idle) begin
            n_err++;
            $display("FAIL %s: bus reads %h, expected released level", name, bus);
        end
    endtask

    initial begin
        logic [3:0] g;
        int         n;
        int         order [6] = '{0, 1, 2, 3, 0, 1};

        rst     = 1'b1;
        req     = 4'b1111;
        wr_data = {8'h3C, 8'hA5, 8'h22, 8'h11};

        // Reset held three cycles with every channel requesting.
        tick(3);
        check("rst_grant", {28'd0, grant}, 32'h0);
        check("rst_valid", {31'd0, bus_valid}, 32'h0);
        check("rst_owner", {30'd0, bus_owner}, 32'h0);
        check("rst_cnt",   {24'd0, beat_cnt}, 32'h0);
        check_idle("rst_bus");
        rst = 1'b0;
        tick(1);
        check("first_grant", {28'd0, grant}, 32'h1);
        check("first_bus",   {24'd0, bus}, 32'h11);

        // Fairness: full tenures of 4 beats, 2-cycle gaps, order 0,1,2,3,0,1.
        for (int k = 1; k < 6; k++) begin
            wait_release(8, n);
            check("tenure_len", n, 32'd4);
            wait_grant(8, g, n);
            check("gap", n, 32'd2);
            check("order", {28'd0, g}, 32'd1 << order[k]);
        end
        req = 4'b0000;
        tick(3);
        check_idle("idle_bus");

        // Early release by channel 2 after two beats.
        req = 4'b0100;
        tick(1);
        check("er_grant", {28'd0, grant}, 32'h4);
        check("er_bus",   {24'd0, bus}, 32'hA5);
        check("er_cnt0",  {24'd0, beat_cnt}, 32'h0);
        tick(1);
        check("er_cnt1",  {24'd0, beat_cnt}, 32'h1);
        check("er_valid", {31'd0, bus_valid}, 32'h1);
        req = 4'b0000;
        tick(1);
        check("er_turn_grant", {28'd0, grant}, 32'h0);
        check("er_turn_valid", {31'd0, bus_valid}, 32'h0);
        check("er_turn_cnt",   {24'd0, beat_cnt}, 32'h1);
        // Request arriving during the turnaround must wait; pointer now sits at 3.
        req = 4'b1001;
        tick(1);
        check("turn_wait", {28'd0, grant}, 32'h0);
        tick(1);
        check("ptr3_grant", {28'd0, grant}, 32'h8);
        wait_release(8, n);
        wait_grant(8, g, n);
        check("ptr3_next", {28'd0, g}, 32'h1);
        req = 4'b0000;
        tick(4);

        // Wrap and skip: pointer at 1 with channels 0 and 3 requesting.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req = 4'b0001;
        tick(1);
        req = 4'b0000;
        tick(2);
        req = 4'b1001;
        tick(1);
        check("wrap_first", {28'd0, grant}, 32'h8);
        wait_release(8, n);
        wait_grant(8, g, n);
        check("wrap_second", {28'd0, g}, 32'h1);
        req = 4'b0000;
        tick(4);

        // Reset during beat 2 of channel 1.
        req = 4'b0010;
        wait_grant(8, g, n);
        check("mid_grant", {28'd0, g}, 32'h2);
        tick(1);
        check("mid_cnt", {24'd0, beat_cnt}, 32'h1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_grant", {28'd0, grant}, 32'h0);
        check("mid_rst_valid", {31'd0, bus_valid}, 32'h0);
        check_idle("mid_rst_bus");
        rst = 1'b0;
        req = 4'b0000;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
